// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop counter controller: FSM state
// encodings and the load-value saturation helper.
package tff_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_HOLD = ST_HOLD
  } state_e;

  // Clamp a loaded value into the legal count range 0..modulus-1.
  function automatic int unsigned sat_mod(input int unsigned val, input int unsigned modulus);
    if (val >= modulus) begin
      return modulus - 32'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-high reset; toggles when t is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic q_q;

  // Toggle storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo-MOD up/down counter built from a bank of T flip-flops; the controller
// only ever changes the bank through the per-bit toggle vector t_vec.
module tff_counter_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] q_eff_s;
  logic [WIDTH-1:0] q_next_s;
  logic             count_s;

  // FSM next state: clear forces IDLE, load freezes the state, stop beats start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (load) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE:  if (start && !stop) state_d = S_RUN;  else state_d = S_IDLE;
        S_RUN:   if (stop)           state_d = S_HOLD; else state_d = S_RUN;
        S_HOLD:  if (start && !stop) state_d = S_RUN;  else state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN);
  end

  // Next counter value and wrap detection; an out-of-range q behaves as MOD-1.
  always_comb begin
    q_eff_s  = (q > MAX_V) ? MAX_V : q;
    count_s  = (state_q == S_RUN) && !stop && !load && !clear;
    q_next_s = q;
    tc_d     = 1'b0;
    if (clear) begin
      q_next_s = '0;
    end else if (load) begin
      q_next_s = WIDTH'(sat_mod(32'(load_val), 32'(MOD)));
    end else if (count_s) begin
      if (up_dn) begin
        if (q_eff_s == MAX_V) begin
          q_next_s = '0;
          tc_d     = 1'b1;
        end else begin
          q_next_s = q_eff_s + ONE_V;
        end
      end else begin
        if (q_eff_s == '0) begin
          q_next_s = MAX_V;
          tc_d     = 1'b1;
        end else begin
          q_next_s = q_eff_s - ONE_V;
        end
      end
    end else begin
      q_next_s = q;
    end
  end

  // The bank is held in reset while rst is high, so no toggles are presented then.
  assign t_vec = rst ? '0 : (q ^ q_next_s);

  // Controller state, busy flag and terminal-count pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
    end
  end

  assign busy = busy_q;
  assign tc   = tc_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (t_vec[i]),
      .q    (q[i]),
      .qbar ()
    );
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed, table-driven bench for tff_counter_ctrl (WIDTH=4, MOD=10).
module tb_tff_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] q, t_vec;
  logic       busy, tc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       start, stop, clear, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] exp_q;
    logic       exp_busy, exp_tc;
  } vec_t;

  vec_t vecs[$];

  tff_counter_ctrl #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(q), .t_vec(t_vec), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic cl, input logic ud,
                     input logic ld, input logic [3:0] lv,
                     input logic [3:0] eq, input logic eb, input logic et);
    vec_t v;
    v.start = st; v.stop = sp; v.clear = cl; v.up_dn = ud; v.load = ld;
    v.load_val = lv; v.exp_q = eq; v.exp_busy = eb; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] prev_q;

    // start  stop clear up_dn load lv   q  busy tc
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);   // IDLE -> RUN, no step yet
    for (int k = 1; k <= 9; k++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'(k), 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);    // 9 -> 0 wrap
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);    // load 0: no tc
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);    // down wrap 0 -> 9
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);    // 1 -> 0: no tc
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0);  // HOLD, frozen
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0);    // HOLD -> RUN
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd6, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 4'd9, 1'b1, 1'b0);   // saturating load
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);    // resumes from 9
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0);    // clear beats load
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);    // start+stop in IDLE
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);    // start+stop in RUN
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 1'b1, 1'b0);

    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tc", 32'(tc), 32'd0);
    chk("reset_tvec", 32'(t_vec), 32'd0);
    rst = 1'b0;

    prev_q = 4'd0;
    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; clear = vecs[i].clear;
      up_dn = vecs[i].up_dn; load = vecs[i].load; load_val = vecs[i].load_val;
      #1;
      chk($sformatf("v%0d_tvec", i), 32'(t_vec), 32'(prev_q ^ vecs[i].exp_q));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      prev_q = vecs[i].exp_q;
    end

    // Asynchronous reset mid-count at q=7, observed before the next edge.
    start = 1'b0; load = 1'b0; up_dn = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(q), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_tc", 32'(tc), 32'd0);
    chk("async_rst_tvec", 32'(t_vec), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_q", 32'(q), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
